// File: rtl/reg_pkg.sv
// Shared types and widths for the register-file writeback path.
package reg_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 3;
  localparam int unsigned NUM_REGS = 8;

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(7);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; prio names the side favoured on contention.
module rr_arb2
  import reg_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  prio_e prio_q;
  prio_e prio_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prio_q <= PRIO_A;
    end else begin
      prio_q <= prio_d;
    end
  end

  // The side just served always loses priority to the other one.
  always_comb begin
    gnt    = 2'b00;
    prio_d = prio_q;
    if (en) begin
      unique case (req)
        2'b11:   gnt = (prio_q == PRIO_A) ? 2'b01 : 2'b10;
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        default: gnt = 2'b00;
      endcase
      if (gnt[0]) begin
        prio_d = PRIO_B;
      end else if (gnt[1]) begin
        prio_d = PRIO_A;
      end
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter for the register file write port; R7 writes are dropped.
// Optional operand bypass of the in-flight write: define WB_FWD_EN.
module reg_wb_arbiter
  import reg_pkg::*;
#(
  parameter int unsigned DATA_W = reg_pkg::DATA_W,
  parameter int unsigned ADDR_W = reg_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              hold,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_value,
  output logic              write_enable,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [DATA_W-1:0] rf_value1,
  input  logic [DATA_W-1:0] rf_value2,
  output logic [DATA_W-1:0] op_value1,
  output logic [DATA_W-1:0] op_value2
);

  wb_req_t    a_req;
  wb_req_t    b_req;
  wb_req_t    sel_req;
  logic [1:0] gnt;

  assign a_req = '{valid: a_valid, addr: a_addr, data: a_data};
  assign b_req = '{valid: b_valid, addr: b_addr, data: b_data};

  // Grants are gated by reset so neither producer sees ready while in reset.
  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({b_req.valid, a_req.valid}),
    .en      (~hold & reset_n),
    .gnt     (gnt)
  );

  assign a_ready = gnt[0];
  assign b_ready = gnt[1];

  always_comb begin
    sel_req       = gnt[1] ? b_req : a_req;
    sel_req.valid = |gnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_value  <= '0;
    end else begin
      write_enable <= sel_req.valid && (sel_req.addr != ZERO_REG);
      if (sel_req.valid) begin
        write_addr  <= sel_req.addr;
        write_value <= sel_req.data;
      end
    end
  end

`ifdef WB_FWD_EN
  // R7 never matches here because its write_enable is never set.
  assign op_value1 = (write_enable && (write_addr == read_addr1)) ? write_value : rf_value1;
  assign op_value2 = (write_enable && (write_addr == read_addr2)) ? write_value : rf_value2;
`else
  logic unused_read_addr;
  assign unused_read_addr = ^{read_addr1, read_addr2};
  assign op_value1 = rf_value1;
  assign op_value2 = rf_value2;
`endif

endmodule
